// File: rtl/mario_sprite_fetch.sv
// Mario sprite pixel stage: box hit-test, pose-ROM addressing, colour-index mux,
// plus the per-frame pose FSM and walk-cycle counter.
`default_nettype none

module mario_sprite_fetch #(
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 30,
  parameter int ANIM_FRAMES = 6,
  parameter int TRANSP_IDX  = 0
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic        frame_start_i,
  input  logic        pix_valid_i,
  input  logic [9:0]  DrawX_i,
  input  logic [9:0]  DrawY_i,
  input  logic [9:0]  MarioX_i,
  input  logic [9:0]  MarioY_i,
  input  logic        is_jumping_i,
  input  logic        is_moving_i,
  input  logic        facing_left_i,
  output logic [12:0] rom_addr_o,
  input  logic [3:0]  idx_runr_i,
  input  logic [3:0]  idx_runl_i,
  input  logic [3:0]  idx_standr_i,
  input  logic [3:0]  idx_standl_i,
  input  logic [3:0]  idx_jumpr_i,
  input  logic [3:0]  idx_jumpl_i,
  output logic        sprite_on_o,
  output logic [3:0]  sprite_idx_o
);

  localparam int SH = $clog2(SPR_W);
  localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_FRAMES - 1);

  typedef enum logic [1:0] {STAND = 2'd0, RUN_A = 2'd1, RUN_B = 2'd2, JUMP = 2'd3} pose_e;

  pose_e         pose_q, pose_d;
  logic          facing_q, facing_d;
  logic [AW-1:0] anim_q, anim_d;

  logic [12:0] addr_d, addr_q;
  logic        hit_d, hit1_q, hit2_q;
  logic [2:0]  sel_d, sel1_q, sel2_q;
  logic [3:0]  idx_mux;
  logic        on_d, on_q;
  logic [3:0]  idx_d, idx_q;

  logic [10:0] x_end, y_end, dx, dy;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      pose_q   <= STAND;
      facing_q <= 1'b0;
      anim_q   <= '0;
      addr_q   <= '0;
      hit1_q   <= 1'b0;
      sel1_q   <= '0;
      hit2_q   <= 1'b0;
      sel2_q   <= '0;
      on_q     <= 1'b0;
      idx_q    <= '0;
    end else begin
      pose_q   <= pose_d;
      facing_q <= facing_d;
      anim_q   <= anim_d;
      addr_q   <= addr_d;
      hit1_q   <= hit_d;
      sel1_q   <= sel_d;
      hit2_q   <= hit1_q;
      sel2_q   <= sel1_q;
      on_q     <= on_d;
      idx_q    <= idx_d;
    end
  end

  // Pose only moves on frame_start, so it is constant across every visible pixel.
  always_comb begin
    pose_d   = pose_q;
    facing_d = facing_q;
    anim_d   = anim_q;
    if (frame_start_i) begin
      facing_d = facing_left_i;
      if (is_jumping_i) begin
        pose_d = JUMP;
      end else if (is_moving_i) begin
        if (pose_q == RUN_A || pose_q == RUN_B) begin
          if (anim_q == ANIM_LAST) begin
            pose_d = (pose_q == RUN_A) ? RUN_B : RUN_A;
            anim_d = '0;
          end else begin
            anim_d = anim_q + 1'b1;
          end
        end else begin
          pose_d = RUN_A;
          anim_d = '0;
        end
      end else begin
        pose_d = STAND;
        anim_d = '0;
      end
    end
  end

  // 11-bit compare so a box hanging past column/row 1023 never wraps to 0.
  always_comb begin
    x_end  = {1'b0, MarioX_i} + 11'(SPR_W);
    y_end  = {1'b0, MarioY_i} + 11'(SPR_H);
    dx     = {1'b0, DrawX_i} - {1'b0, MarioX_i};
    dy     = {1'b0, DrawY_i} - {1'b0, MarioY_i};
    hit_d  = pix_valid_i
           && ({1'b0, DrawX_i} >= {1'b0, MarioX_i}) && ({1'b0, DrawX_i} < x_end)
           && ({1'b0, DrawY_i} >= {1'b0, MarioY_i}) && ({1'b0, DrawY_i} < y_end);
    addr_d = hit_d ? ((13'(dy) << SH) + 13'(dx)) : 13'd0;
    unique case (pose_q)
      RUN_A:   sel_d = {2'd0, facing_q};
      JUMP:    sel_d = {2'd2, facing_q};
      default: sel_d = {2'd1, facing_q};
    endcase
  end

  always_comb begin
    unique case (sel2_q)
      3'b000:  idx_mux = idx_runr_i;
      3'b001:  idx_mux = idx_runl_i;
      3'b010:  idx_mux = idx_standr_i;
      3'b011:  idx_mux = idx_standl_i;
      3'b100:  idx_mux = idx_jumpr_i;
      3'b101:  idx_mux = idx_jumpl_i;
      default: idx_mux = 4'd0;
    endcase
    on_d  = hit2_q && (idx_mux != 4'(TRANSP_IDX));
    idx_d = on_d ? idx_mux : 4'd0;
  end

  assign rom_addr_o   = addr_q;
  assign sprite_on_o  = on_q;
  assign sprite_idx_o = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_mario_sprite_fetch.sv
// Randomised scoreboard bench for mario_sprite_fetch with six modelled pose ROMs.
`default_nettype none

module tb_mario_sprite_fetch;

  localparam int ANIM = 6;

  logic        clk = 1'b0;
  logic        rst, fs, pv, jmp, mov, fl;
  logic [9:0]  dx, dy, mx, my;
  logic [12:0] rom_addr;
  logic [3:0]  idx [6];
  logic        spr_on;
  logic [3:0]  spr_idx;

  logic [3:0]  rom [6][512];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {int due; logic [12:0] addr; logic on; logic [3:0] id;} exp_t;
  exp_t qa[$];
  exp_t qp[$];

  // Reference pose state: running frame count since the run began (-1 = not running).
  bit m_jump;
  int m_run;
  bit m_face;

  mario_sprite_fetch dut (
    .Clk_i(clk), .Reset_i(rst), .frame_start_i(fs), .pix_valid_i(pv),
    .DrawX_i(dx), .DrawY_i(dy), .MarioX_i(mx), .MarioY_i(my),
    .is_jumping_i(jmp), .is_moving_i(mov), .facing_left_i(fl),
    .rom_addr_o(rom_addr),
    .idx_runr_i(idx[0]), .idx_runl_i(idx[1]), .idx_standr_i(idx[2]),
    .idx_standl_i(idx[3]), .idx_jumpr_i(idx[4]), .idx_jumpl_i(idx[5]),
    .sprite_on_o(spr_on), .sprite_idx_o(spr_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    for (int k = 0; k < 6; k++) idx[k] <= rom[k][rom_addr[8:0]];

  // Monitor: compares whatever the scoreboard says is due after this edge.
  always @(posedge clk) begin
    #2;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      exp_t e;
      e = qa.pop_front();
      n_vec++;
      if (rom_addr !== e.addr) begin
        n_err++;
        $display("FAIL rom_addr cyc=%0d got=%0d exp=%0d", cyc, rom_addr, e.addr);
      end
    end
    while (qp.size() > 0 && qp[0].due <= cyc) begin
      exp_t e;
      e = qp.pop_front();
      n_vec++;
      if (spr_on !== e.on || spr_idx !== e.id) begin
        n_err++;
        $display("FAIL pixel cyc=%0d got on=%b idx=%0d exp on=%b idx=%0d",
                 cyc, spr_on, spr_idx, e.on, e.id);
      end
    end
  end

  function automatic int rom_sel();
    int kind;
    if (m_jump) kind = 2;
    else if (m_run >= 0 && ((m_run / ANIM) % 2) == 0) kind = 0;
    else kind = 1;
    return kind * 2 + int'(m_face);
  endfunction

  task automatic step(input bit r, input bit f, input bit v, input int x, input int y,
                      input int px, input int py, input bit j, input bit m, input bit l);
    exp_t e;
    int   c, ax, ay, off, val;
    bit   hit;
    @(negedge clk);
    rst = r; fs = f; pv = v; jmp = j; mov = m; fl = l;
    dx = 10'(x); dy = 10'(y); mx = 10'(px); my = 10'(py);
    c = cyc;
    if (r) begin
      while (qa.size() > 0 && qa[$].due > c) void'(qa.pop_back());
      while (qp.size() > 0 && qp[$].due > c) void'(qp.pop_back());
      e.addr = '0; e.on = 1'b0; e.id = '0;
      e.due = c + 1; qa.push_back(e);
      for (int d = 1; d <= 3; d++) begin e.due = c + d; qp.push_back(e); end
      m_jump = 0; m_run = -1; m_face = 0;
    end else begin
      ax = int'(dx); ay = int'(dy);
      hit = v && ax >= int'(mx) && ax < int'(mx) + 16 && ay >= int'(my) && ay < int'(my) + 30;
      off = hit ? (ay - int'(my)) * 16 + (ax - int'(mx)) : 0;
      val = int'(rom[rom_sel()][off]);
      e.addr = 13'(off);
      e.on   = hit && val != 0;
      e.id   = e.on ? 4'(val) : 4'd0;
      e.due = c + 1; qa.push_back(e);
      e.due = c + 3; qp.push_back(e);
      if (f) begin
        m_face = l;
        if (j) m_jump = 1;
        else if (m) begin
          if (m_jump || m_run < 0) m_run = 0; else m_run++;
          m_jump = 0;
        end else begin
          m_jump = 0; m_run = -1;
        end
      end
    end
  endtask

  initial begin
    int px, py, x, y;
    bit j, m, l;
    rst = 1; fs = 0; pv = 0; jmp = 0; mov = 0; fl = 0;
    dx = 0; dy = 0; mx = 0; my = 0;
    for (int k = 0; k < 6; k++) begin
      idx[k] = 4'd0;
      for (int a = 0; a < 512; a++)
        rom[k][a] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    end
    rom[2][0] = 4'd7;   // first-pixel check uses an opaque stand-right colour
    rom[2][1] = 4'd0;   // and a transparent one right next to it

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Box corners and just-outside neighbours.
    step(0, 0, 1, 100, 200, 100, 200, 0, 0, 0);
    step(0, 0, 1, 101, 200, 100, 200, 0, 0, 0);
    step(0, 0, 1, 115, 229, 100, 200, 0, 0, 0);
    step(0, 0, 1, 116, 229, 100, 200, 0, 0, 0);
    step(0, 0, 1, 115, 230, 100, 200, 0, 0, 0);
    step(0, 0, 1,  99, 200, 100, 200, 0, 0, 0);
    step(0, 0, 0, 105, 205, 100, 200, 0, 0, 0);
    // No wrap past column 1023.
    step(0, 0, 1,    5, 210, 1015, 200, 0, 0, 0);
    step(0, 0, 1, 1020, 210, 1015, 200, 0, 0, 0);
    // Walk cycle, facing left: 13 strobes, each strobe pixel in the box.
    for (int s = 0; s < 13; s++) begin
      step(0, 1, 1, 100 + s, 200 + s, 100, 200, 0, 1, 1);
      step(0, 0, 1, 100 + s, 200 + s, 100, 200, 0, 1, 1);
    end
    // Jump with moving held, then land and run again.
    step(0, 1, 1, 103, 210, 100, 200, 1, 1, 0);
    step(0, 0, 1, 103, 210, 100, 200, 1, 1, 0);
    step(0, 1, 1, 104, 211, 100, 200, 0, 1, 0);
    step(0, 0, 1, 104, 211, 100, 200, 0, 1, 0);
    // Reset in the middle of a stream of in-box pixels.
    step(0, 0, 1, 106, 215, 100, 200, 0, 1, 0);
    step(1, 0, 1, 107, 215, 100, 200, 0, 1, 0);
    step(0, 0, 1, 108, 215, 100, 200, 0, 1, 0);

    px = 300; py = 100; j = 0; m = 0; l = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        px = ($urandom_range(0, 7) == 0) ? $urandom_range(1005, 1023) : $urandom_range(0, 1023);
        py = ($urandom_range(0, 7) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 1023);
      end
      if ($urandom_range(0, 49) == 0) begin
        j = ($urandom_range(0, 3) == 0); m = $urandom_range(0, 1) != 0; l = $urandom_range(0, 1) != 0;
      end
      if ($urandom_range(0, 9) < 7) begin
        x = (px + $urandom_range(0, 18) - 1) & 1023;
        y = (py + $urandom_range(0, 32) - 1) & 1023;
      end else begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
      end
      step($urandom_range(0, 699) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) != 0, x, y, px, py, j, m, l);
    end

    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, px, py, 0, 0, 0);
    repeat (5) @(posedge clk);
    #3;
    n_vec++;
    if (qa.size() != 0 || qp.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d/%0d pending exp=0", qa.size(), qp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
